// File: rtl/card_round_sequencer_if.sv
// Keypad, card-datapath and status signals of the card round sequencer.
// master = sequencer side, slave = keypad/datapath/display side.
interface card_round_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       card_ready;
    logic [2:0] card_num;
    logic       draw_req;
    logic       draw_whose;
    logic [5:0] sum_p1;
    logic [5:0] sum_p2;
    logic [5:0] deck_left;
    logic [2:0] state_o;
    logic [1:0] winner;
    logic       round_done;
    logic       timeout_err;

    modport master (
        input  key_valid, key_code, card_ready, card_num,
        output draw_req, draw_whose, sum_p1, sum_p2, deck_left,
               state_o, winner, round_done, timeout_err
    );

    modport slave (
        output key_valid, key_code, card_ready, card_num,
        input  draw_req, draw_whose, sum_p1, sum_p2, deck_left,
               state_o, winner, round_done, timeout_err
    );
endinterface

// File: rtl/card_round_sequencer.sv
// Two-player card round controller: keypad commands in, draw strobes out, totals and winner.
// Define CARD_AUTO_DEALER_EN to make player 2 a machine dealer that draws below DEALER_STAND.
module card_round_sequencer #(
    parameter int         DECK_SIZE    = 40,
    parameter int         TARGET       = 21,
    parameter int         MAX_CARDS    = 5,
    parameter int         WAIT_MAX     = 255,
    parameter logic [3:0] KEY_DRAW     = 4'd1,
    parameter logic [3:0] KEY_STAND    = 4'd2,
    parameter logic [3:0] KEY_NEW      = 4'd12,
    parameter int         DEALER_STAND = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    card_round_sequencer_if.master       bus
);

    // state   | meaning
    // IDLE    | no round yet, waiting for new-round key
    // P1_TURN | player 1 may draw or stand
    // P1_WAIT | player 1 draw outstanding
    // P2_TURN | player 2 may draw or stand
    // P2_WAIT | player 2 draw outstanding
    // JUDGE   | compare totals (one cycle)
    // DONE    | winner held until next new-round key
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1_TURN = 3'd1,
        P1_WAIT = 3'd2,
        P2_TURN = 3'd3,
        P2_WAIT = 3'd4,
        JUDGE   = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic [5:0] DECK_FULL = 6'(DECK_SIZE);
    localparam logic [5:0] BUST_LIM  = 6'(TARGET);
    localparam logic [2:0] CARD_MAX  = 3'(MAX_CARDS);
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_MAX - 1);
`ifdef CARD_AUTO_DEALER_EN
    localparam logic [5:0] DEALER_LIM = 6'(DEALER_STAND);
`endif

    state_e     state_q;
    logic [5:0] sum_p1_q, sum_p2_q, deck_q;
    logic [2:0] cnt_p1_q, cnt_p2_q;
    logic [7:0] wait_q;
    logic [1:0] winner_q;
    logic       draw_req_q, whose_q, done_q, tmo_q;

    logic       key_draw, key_stand, key_new;
    logic [5:0] new_sum_d;
    logic [2:0] new_cnt_d;
    logic       bust_d;

    assign key_draw  = bus.key_valid && (bus.key_code == KEY_DRAW);
    assign key_stand = bus.key_valid && (bus.key_code == KEY_STAND);
    assign key_new   = bus.key_valid && (bus.key_code == KEY_NEW);

    // Running total of whichever player the outstanding draw belongs to.
    assign new_sum_d = (whose_q ? sum_p2_q : sum_p1_q) + {3'b000, bus.card_num} + 6'd1;
    assign new_cnt_d = (whose_q ? cnt_p2_q : cnt_p1_q) + 3'd1;
    assign bust_d    = new_sum_d > BUST_LIM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sum_p1_q   <= '0;
            sum_p2_q   <= '0;
            cnt_p1_q   <= '0;
            cnt_p2_q   <= '0;
            deck_q     <= DECK_FULL;
            wait_q     <= '0;
            winner_q   <= 2'b00;
            draw_req_q <= 1'b0;
            whose_q    <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            draw_req_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (key_new) begin
                        state_q  <= P1_TURN;
                        sum_p1_q <= '0;
                        sum_p2_q <= '0;
                        cnt_p1_q <= '0;
                        cnt_p2_q <= '0;
                        deck_q   <= DECK_FULL;
                        winner_q <= 2'b00;
                        whose_q  <= 1'b0;
                        done_q   <= 1'b0;
                        tmo_q    <= 1'b0;
                    end
                end
                P1_TURN: begin
                    if (deck_q == 6'd0) begin
                        state_q <= P2_TURN;
                    end else if (key_draw) begin
                        if (cnt_p1_q == CARD_MAX) begin
                            state_q <= P2_TURN;
                        end else begin
                            state_q    <= P1_WAIT;
                            draw_req_q <= 1'b1;
                            whose_q    <= 1'b0;
                            deck_q     <= deck_q - 6'd1;
                            wait_q     <= WAIT_LOAD;
                        end
                    end else if (key_stand) begin
                        state_q <= P2_TURN;
                    end
                end
                P2_TURN: begin
`ifdef CARD_AUTO_DEALER_EN
                    if (deck_q == 6'd0 || cnt_p2_q == CARD_MAX || sum_p2_q >= DEALER_LIM) begin
                        state_q <= JUDGE;
                    end else begin
                        state_q    <= P2_WAIT;
                        draw_req_q <= 1'b1;
                        whose_q    <= 1'b1;
                        deck_q     <= deck_q - 6'd1;
                        wait_q     <= WAIT_LOAD;
                    end
`else
                    if (deck_q == 6'd0) begin
                        state_q <= JUDGE;
                    end else if (key_draw) begin
                        if (cnt_p2_q == CARD_MAX) begin
                            state_q <= JUDGE;
                        end else begin
                            state_q    <= P2_WAIT;
                            draw_req_q <= 1'b1;
                            whose_q    <= 1'b1;
                            deck_q     <= deck_q - 6'd1;
                            wait_q     <= WAIT_LOAD;
                        end
                    end else if (key_stand) begin
                        state_q <= JUDGE;
                    end
`endif
                end
                P1_WAIT, P2_WAIT: begin
                    if (bus.card_ready) begin
                        if (whose_q) begin
                            sum_p2_q <= new_sum_d;
                            cnt_p2_q <= new_cnt_d;
                        end else begin
                            sum_p1_q <= new_sum_d;
                            cnt_p1_q <= new_cnt_d;
                        end
                        if (bust_d) begin
                            winner_q <= whose_q ? 2'b01 : 2'b10;
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                        end else if (new_cnt_d == CARD_MAX) begin
                            state_q <= whose_q ? JUDGE : P2_TURN;
                        end else begin
                            state_q <= whose_q ? P2_TURN : P1_TURN;
                        end
                    end else if (wait_q == 8'd0) begin
                        // Deck is not refunded: the datapath may still have consumed a card.
                        tmo_q   <= 1'b1;
                        state_q <= whose_q ? P2_TURN : P1_TURN;
                    end else begin
                        wait_q <= wait_q - 8'd1;
                    end
                end
                JUDGE: begin
                    if (sum_p1_q > sum_p2_q)      winner_q <= 2'b01;
                    else if (sum_p1_q < sum_p2_q) winner_q <= 2'b10;
                    else                          winner_q <= 2'b11;
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.draw_req    = draw_req_q;
    assign bus.draw_whose  = whose_q;
    assign bus.sum_p1      = sum_p1_q;
    assign bus.sum_p2      = sum_p2_q;
    assign bus.deck_left   = deck_q;
    assign bus.state_o     = state_q;
    assign bus.winner      = winner_q;
    assign bus.round_done  = done_q;
    assign bus.timeout_err = tmo_q;

endmodule

// File: doc/card_round_sequencer.md
Name: card_round_sequencer

Overview:
- Round controller for the two-player card game. Decodes keypad commands (draw / stand / new round) and issues one-cycle draw requests to the shared random-card datapath, tagged with the requesting player.
- Accumulates each player's hand total from returned card numbers and judges the winner.
- Sits between keypad_scan and the rand_gen / counter / demux / card_value chain. It replaces free-running turn toggling with a sequenced round.

Parameters:
- DECK_SIZE, 40, cards available per round; deck_left reloads to this value at round start.
- TARGET, 21, bust threshold; a hand total greater than TARGET is a bust.
- MAX_CARDS, 5, maximum cards per player per round; reaching it forces a stand.
- WAIT_MAX, 255, cycles to wait for card_ready before declaring a timeout.
- KEY_DRAW, 4'd1, key code for draw.
- KEY_STAND, 4'd2, key code for stand.
- KEY_NEW, 4'd12, key code for new round.
- DEALER_STAND, 17, auto-dealer stands at a total at or above this (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle pulse; key_code is valid in that cycle
- key_code  in  4  scanned key index
- card_ready  in  1  one-cycle pulse from the datapath; card_num is valid in that cycle
- card_num  in  3  drawn card number 0..7; card value = card_num+1
- draw_req  out  1  one-cycle draw strobe to rand_gen/counter
- draw_whose  out  1  0 = player 1, 1 = player 2; held stable from draw_req until card_ready
- sum_p1  out  6  player 1 hand total
- sum_p2  out  6  player 2 hand total
- deck_left  out  6  cards remaining in the deck
- state_o  out  3  FSM state encoding
- winner  out  2  00 none, 01 P1, 10 P2, 11 tie
- round_done  out  1  high while in DONE
- timeout_err  out  1  sticky; cleared at round start

Behaviour:
- Reset values: state IDLE; sums 0; card counts 0; deck_left = DECK_SIZE; winner 00; draw_req 0; draw_whose 0; round_done 0; timeout_err 0.
- Reset asserted in any state, including while a draw is outstanding, aborts the round. A card_ready arriving after reset is ignored.
- State encodings: IDLE=0, P1_TURN=1, P1_WAIT=2, P2_TURN=3, P2_WAIT=4, JUDGE=5, DONE=6.
- IDLE:
  - KEY_NEW -> P1_TURN.
  - On this transition: clear sums, card counts, winner and timeout_err; reload deck_left.
  - All other keys are ignored.
- Px_TURN, on KEY_DRAW:
  - If deck_left == 0 or that player's card count == MAX_CARDS, the key is treated as a stand.
  - Otherwise, in the next cycle: draw_req = 1 for exactly one cycle, draw_whose = x-1, and deck_left decrements. State -> Px_WAIT.
- Px_TURN, on KEY_STAND: P1 -> P2_TURN; P2 -> JUDGE.
- Px_WAIT:
  - All keys are ignored, including when key_valid and card_ready coincide.
  - On card_ready: sum_px += card_num+1 and card count += 1, registered and visible the cycle after card_ready.
  - Bust check on the new sum:
    - P1 bust: winner = 10; go directly to DONE.
    - P2 bust: winner = 01; -> DONE.
  - No bust: return to Px_TURN.
  - If this was the player's MAX_CARDS-th card, stand automatically: P1 -> P2_TURN, P2 -> JUDGE.
  - If card_ready is not seen within WAIT_MAX cycles of draw_req: set timeout_err, return to Px_TURN, leave sum and count unchanged, do not restore deck_left.
  - A card_ready received in any non-WAIT state is ignored.
- Deck empty: entering Px_TURN with deck_left == 0 forces a stand in that same cycle.
- JUDGE lasts one cycle:
  - sum_p1 > sum_p2 -> 01.
  - sum_p1 < sum_p2 -> 10.
  - Equal -> 11.
  - Then -> DONE.
- DONE: round_done = 1. KEY_NEW starts a new round directly (same actions as the IDLE transition). Other keys are ignored.
- Width rule: the maximum total is MAX_CARDS*8 = 40, which fits in 6 bits. No saturation logic is needed.

Optional Feature:
- Macro: CARD_AUTO_DEALER_EN.
- When defined:
  - Player 2 is machine-controlled. P2_TURN ignores keys.
  - While sum_p2 < DEALER_STAND and a draw is legal, it issues a draw one cycle after entering P2_TURN.
  - Otherwise it stands.
- When undefined: P2 is keypad-driven as described above.

Test Plan:
- Reset then KEY_NEW -> state 1, deck_left 40, sums 0, winner 00. KEY_DRAW -> draw_req high exactly 1 cycle, draw_whose 0, deck_left 39.
- P1 draws card_num 6,6,6 (7+7+7 = 21), stands; P2 draws 6,5 (7+6 = 13), stands -> JUDGE -> winner 01, round_done 1.
- P1 draws 7,7,7 (8+8+8 = 24 > 21) -> winner 10 and DONE the cycle after the 3rd card_ready; P2 never gets a turn.
- P1 issues KEY_DRAW with no card_ready for 255 cycles -> timeout_err 1, state back to 1, sum_p1 unchanged. key_valid coinciding with card_ready in WAIT -> key ignored, card accepted.
- P1 draws 5 cards of card_num 0 (sum 5) -> auto stand to state 3. Equal totals 5/5 -> winner 11. KEY_NEW in DONE -> sums 0, deck reloaded to 40.
- With CARD_AUTO_DEALER_EN: P1 stands at 10; P2 auto-draws 7,7,7 -> P2 busts at 24 on the 3rd card -> winner 01. Assert rst mid-wait -> all outputs at reset values next cycle.
